// File: rtl/clk_period_meter_pkg.sv
// Shared types and helpers for the clock period meter.
// Holds the measurement FSM state encoding and the counter ceiling helper.
package clk_period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        TIMED_OUT
    } state_t;

    // All-ones value of a width-bit counter; callers cast the result down to their width.
    function automatic logic [63:0] cnt_max(input int unsigned width);
        if (width >= 64) begin
            return '1;
        end
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, with registered rise/fall detect.
// Everything is reset to 0 asynchronously and runs every cycle.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_dly_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q      <= '0;
            level_dly_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], d};
            level_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_dly_q;
    assign fall  = ~level & level_dly_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow signal in main-clock cycles.
// Each finished rising-to-rising interval is published with a one-cycle valid pulse.
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             ena,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             overflow,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(WIDTH));
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [WIDTH-1:0] TO_LAST = TO_EN ? WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    logic s, rise, fall;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (sig_in),
        .level(s),
        .rise (rise),
        .fall (fall)
    );

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
    logic [WIDTH-1:0] hi_hold_q, hi_hold_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             timeout_q, timeout_d;

    logic [WIDTH-1:0] cnt_inc, hi_inc;
    logic             cnt_at_max;

    always_comb begin
        cnt_at_max = (cnt_q == CNT_MAX);
        cnt_inc    = cnt_at_max ? CNT_MAX : cnt_q + WIDTH'(1);
        hi_inc     = (hi_cnt_q == CNT_MAX) ? CNT_MAX : hi_cnt_q + WIDTH'(1);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_cnt_d    = hi_cnt_q;
        hi_hold_d   = hi_hold_q;
        sat_d       = sat_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;
        timeout_d   = timeout_q;

        if (!ena) begin
            // Drop any partial measurement; published results keep their values.
            state_d   = IDLE;
            cnt_d     = '0;
            hi_cnt_d  = '0;
            hi_hold_d = CNT_MAX;
            sat_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d     = '0;
                    hi_cnt_d  = '0;
                    hi_hold_d = CNT_MAX;
                    sat_d     = 1'b0;
                    state_d   = ARM;
                end
                ARM, TIMED_OUT: begin
                    if (rise) begin
                        cnt_d     = '0;
                        hi_cnt_d  = '0;
                        hi_hold_d = CNT_MAX;
                        sat_d     = 1'b0;
                        state_d   = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d    = cnt_inc;
                        high_time_d = hi_hold_q;
                        overflow_d  = sat_q | cnt_at_max;
                        valid_d     = 1'b1;
                        timeout_d   = 1'b0;
                        cnt_d       = '0;
                        hi_cnt_d    = '0;
                        hi_hold_d   = CNT_MAX;
                        sat_d       = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                        sat_d = sat_q | cnt_at_max;
                        if (s) begin
                            hi_cnt_d = hi_inc;
                        end
                        if (fall) begin
                            hi_hold_d = hi_inc;
                        end
                        if (TO_EN && (cnt_q == TO_LAST)) begin
                            state_d   = TIMED_OUT;
                            timeout_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_cnt_q    <= '0;
            hi_hold_q   <= '0;
            sat_q       <= 1'b0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            hi_hold_q   <= hi_hold_d;
            sat_q       <= sat_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: a WIDTH=16/timeout=200 unit and a WIDTH=8 unit.
// Table vectors cover steady waveforms; hand sequences cover timing, timeout, reset and enable.
module tb_clk_period_meter;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic ena = 1'b0;
    logic sig_a = 1'b0;
    logic sig_b = 1'b0;

    logic [15:0] period_a, high_time_a;
    logic        valid_a, overflow_a, timeout_a;
    logic [7:0]  period_b, high_time_b;
    logic        valid_b, overflow_b, timeout_b;

    always #5 clk = ~clk;

    clk_period_meter #(
        .WIDTH(16), .SYNC_STAGES(2), .TIMEOUT_CYCLES(200)
    ) dut_a (
        .clk(clk), .nrst(nrst), .ena(ena), .sig_in(sig_a),
        .period(period_a), .high_time(high_time_a), .valid(valid_a),
        .overflow(overflow_a), .timeout(timeout_a)
    );

    clk_period_meter #(
        .WIDTH(8), .SYNC_STAGES(2), .TIMEOUT_CYCLES(0)
    ) dut_b (
        .clk(clk), .nrst(nrst), .ena(ena), .sig_in(sig_b),
        .period(period_b), .high_time(high_time_b), .valid(valid_b),
        .overflow(overflow_b), .timeout(timeout_b)
    );

    typedef struct {
        int p;
        int h;
        bit o;
        bit t;
        int c;
    } rec_t;

    typedef struct {
        bit unit_b;
        int high;
        int low;
        int nper;
        int exp_p;
        int exp_h;
        bit exp_o;
    } vec_t;

    int   cyc = 0;
    rec_t qa[$];
    rec_t qb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle with valid high is logged, so a stretched pulse shows up as extra records.
    always @(negedge clk) begin
        if (valid_a) qa.push_back('{p: int'(period_a), h: int'(high_time_a), o: overflow_a,
                                    t: timeout_a, c: cyc});
        if (valid_b) qb.push_back('{p: int'(period_b), h: int'(high_time_b), o: overflow_b,
                                    t: timeout_b, c: cyc});
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_sig(input bit unit_b, input bit v);
        if (unit_b) sig_b = v;
        else sig_a = v;
    endtask

    // Park both units in ARM with a low, fully flushed synchroniser.
    task automatic rearm();
        ena = 1'b0;
        sig_a = 1'b0;
        sig_b = 1'b0;
        step(6);
        ena = 1'b1;
        step(2);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   base;
        rec_t r;
        rearm();
        base = v.unit_b ? qb.size() : qa.size();
        for (int n = 0; n < v.nper; n++) begin
            set_sig(v.unit_b, 1'b1);
            step(v.high);
            set_sig(v.unit_b, 1'b0);
            step(v.low);
        end
        // Closing rise ends the last period.
        set_sig(v.unit_b, 1'b1);
        step(4);
        set_sig(v.unit_b, 1'b0);
        step(4);
        chk($sformatf("vec%0d_count", idx),
            (v.unit_b ? qb.size() : qa.size()) - base, v.nper);
        for (int i = base; i < (v.unit_b ? qb.size() : qa.size()); i++) begin
            r = v.unit_b ? qb[i] : qa[i];
            chk($sformatf("vec%0d_period", idx), r.p, v.exp_p);
            chk($sformatf("vec%0d_high", idx), r.h, v.exp_h);
            chk($sformatf("vec%0d_ovf", idx), r.o, v.exp_o);
            chk($sformatf("vec%0d_tmo", idx), r.t, 0);
        end
    endtask

    vec_t vecs[9];

    initial begin
        int base, idx, lv, guard;
        logic [31:0] tv;

        vecs[0] = '{0, 4, 6, 3, 10, 4, 0};
        vecs[1] = '{0, 8, 8, 3, 16, 8, 0};
        vecs[2] = '{0, 1, 1, 4, 2, 1, 0};
        vecs[3] = '{0, 3, 9, 3, 12, 3, 0};
        vecs[4] = '{0, 19, 1, 2, 20, 19, 0};
        vecs[5] = '{1, 150, 150, 2, 255, 150, 1};
        vecs[6] = '{1, 50, 50, 2, 100, 50, 0};
        vecs[7] = '{1, 100, 155, 2, 255, 100, 0};
        vecs[8] = '{1, 260, 40, 1, 255, 255, 1};

        // Reset state
        #2;
        chk("rst_period_a", period_a, 0);
        chk("rst_high_a", high_time_a, 0);
        chk("rst_valid_a", valid_a, 0);
        chk("rst_ovf_a", overflow_a, 0);
        chk("rst_tmo_a", timeout_a, 0);
        chk("rst_period_b", period_b, 0);
        step(3);
        nrst = 1'b1;
        step(2);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Divider bit 3 of a free-running count: first valid lands 3 cycles after the second rise.
        rearm();
        idx = qa.size();
        base = cyc;
        for (int t = 0; t < 80; t++) begin
            tv = t;
            sig_a = tv[3];
            step(1);
        end
        sig_a = 1'b0;
        chk("div_count", qa.size() - idx, 4);
        if (qa.size() > idx) chk("div_first_valid_cyc", qa[idx].c - base, 27);
        for (int i = idx; i < qa.size(); i++) begin
            chk("div_period", qa[i].p, 16);
            chk("div_high", qa[i].h, 8);
        end

        // Enable dropped for 5 cycles in the low phase of a period-12 wave.
        rearm();
        idx = qa.size();
        base = cyc;
        for (int t = 0; t < 90; t++) begin
            sig_a = ((t % 12) < 6);
            ena = !(t >= 44 && t <= 48);
            if (t == 47) begin
                chk("ena_hold_period", period_a, 12);
                chk("ena_hold_valid", valid_a, 0);
            end
            step(1);
        end
        sig_a = 1'b0;
        chk("ena_count", qa.size() - idx, 6);
        if (qa.size() - idx == 6) begin
            chk("ena_v2_cyc", qa[idx + 2].c - base, 39);
            chk("ena_v3_cyc", qa[idx + 3].c - base, 63);
            for (int i = idx; i < qa.size(); i++) chk("ena_period", qa[i].p, 12);
        end

        // Timeout after the wave stops, then restart.
        rearm();
        idx = qa.size();
        for (int n = 0; n < 3; n++) begin
            sig_a = 1'b1;
            step(10);
            sig_a = 1'b0;
            step(10);
        end
        sig_a = 1'b1;
        step(10);
        sig_a = 1'b0;
        chk("tmo_pre_count", qa.size() - idx, 3);
        lv = (qa.size() > 0) ? qa[qa.size() - 1].c : cyc;
        chk("tmo_pre_period", period_a, 20);
        guard = 0;
        while (cyc < lv + 199 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("tmo_wait_cyc", cyc, lv + 199);
        chk("tmo_not_yet", timeout_a, 0);
        @(negedge clk);
        chk("tmo_raised", timeout_a, 1);
        step(5);
        idx = qa.size();
        sig_a = 1'b1;
        step(10);
        sig_a = 1'b0;
        step(10);
        chk("tmo_first_rise_novalid", qa.size() - idx, 0);
        chk("tmo_held", timeout_a, 1);
        sig_a = 1'b1;
        step(5);
        chk("tmo_second_rise_count", qa.size() - idx, 1);
        if (qa.size() > idx) begin
            chk("tmo_restart_period", qa[idx].p, 20);
            chk("tmo_restart_high", qa[idx].h, 10);
            chk("tmo_restart_tflag", qa[idx].t, 0);
        end
        chk("tmo_cleared", timeout_a, 0);
        sig_a = 1'b0;

        // Asynchronous reset mid-measurement, between clock edges.
        rearm();
        sig_a = 1'b1;
        step(10);
        sig_a = 1'b0;
        step(3);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_period_a", period_a, 0);
        chk("arst_high_a", high_time_a, 0);
        chk("arst_valid_a", valid_a, 0);
        chk("arst_ovf_a", overflow_a, 0);
        chk("arst_tmo_a", timeout_a, 0);
        chk("arst_period_b", period_b, 0);
        chk("arst_high_b", high_time_b, 0);
        chk("arst_ovf_b", overflow_b, 0);
        step(2);
        nrst = 1'b1;
        step(4);
        idx = qa.size();
        sig_a = 1'b1;
        step(4);
        sig_a = 1'b0;
        step(6);
        chk("arst_first_rise_novalid", qa.size() - idx, 0);
        sig_a = 1'b1;
        step(4);
        sig_a = 1'b0;
        step(6);
        chk("arst_second_rise_count", qa.size() - idx, 1);
        if (qa.size() > idx) begin
            chk("arst_period", qa[idx].p, 10);
            chk("arst_high", qa[idx].h, 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
